// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial source stage: accepts WIDTH-bit words over valid/ready and emits one bit per
// clock on x. A one-word holding buffer lets back-to-back words stream with no idle gap.
module seq_bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] hold_data_q;
   logic             hold_full_q;

   logic             accept;
   logic             last_bit;
   logic             load;
   logic [WIDTH-1:0] load_word;
   logic [WIDTH-1:0] shifted;

   // The bit currently on x always sits at the outgoing end of the shift register.
   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign in_ready  = !hold_full_q;
   assign busy      = (state_q == StShift) || hold_full_q;
   assign accept    = in_valid && in_ready;
   assign last_bit  = (state_q == StShift) && (bit_idx_q == LAST_IDX);
   // A held word always wins over the input; in IDLE the hold buffer is necessarily empty.
   assign load      = ((state_q == StIdle) && accept) || (last_bit && (hold_full_q || accept));
   assign load_word = hold_full_q ? hold_data_q : in_data;
   assign shifted   = advance(shreg_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         x           <= IDLE_BIT;
         x_valid     <= 1'b0;
         sof         <= 1'b0;
         eof         <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         if (last_bit) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end

         if (load) begin
            state_q     <= StShift;
            bit_idx_q   <= '0;
            shreg_q     <= load_word;
            hold_full_q <= 1'b0;
            x           <= lead_bit(load_word);
            x_valid     <= 1'b1;
            sof         <= 1'b1;
            eof         <= 1'b0;
         end else if (state_q == StShift && !last_bit) begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            shreg_q   <= shifted;
            x         <= lead_bit(shifted);
            x_valid   <= 1'b1;
            sof       <= 1'b0;
            eof       <= (bit_idx_q == LAST_IDX - IDX_W'(1));
            if (accept) begin
               hold_data_q <= in_data;
               hold_full_q <= 1'b1;
            end
         end else begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: a queue-of-bits reference model predicts every
// output each cycle; scenario tasks add directed checks for the documented cases.
module tb_seq_bit_serializer;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, x, x_valid, sof, eof, busy;
   logic [7:0] frame_cnt;

   logic [7:0] l_in_data = '0;
   logic       l_in_valid = 1'b0;
   logic       l_in_ready, l_x, l_x_valid, l_sof, l_eof, l_busy;
   logic [7:0] l_frame_cnt;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .x_valid(x_valid), .sof(sof), .eof(eof), .busy(busy), .frame_cnt(frame_cnt)
   );

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(8)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .x(l_x), .x_valid(l_x_valid), .sof(l_sof), .eof(l_eof), .busy(l_busy),
      .frame_cnt(l_frame_cnt)
   );

   // Reference model: bits still to be emitted, head = bit currently on x.
   typedef struct packed {
      logic b;
      logic s;
      logic e;
   } ent_t;

   ent_t        mq[$];
   logic [7:0]  mcnt = '0;
   logic [7:0]  src[$];
   bit          pend = 1'b0;
   int unsigned gap_pct = 0;

   logic [13:0] dut_vec;
   assign dut_vec = {x, x_valid, sof, eof, in_ready, busy, frame_cnt};

   // At most one word fits besides the one in flight, so ready means no more than W bits queued.
   function automatic logic [13:0] exp_vec();
      if (mq.size() > 0)
         return {mq[0].b, 1'b1, mq[0].s, mq[0].e, (mq.size() <= W), 1'b1, mcnt};
      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mcnt};
   endfunction

   always @(posedge clk) begin
      ent_t e;
      bit   acc;
      if (!rst) begin
         mq.delete();
         mcnt = '0;
      end else begin
         acc = in_valid && (mq.size() <= W);
         if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.e) mcnt = mcnt + 8'd1;
         end
         if (acc) begin
            for (int i = 0; i < W; i++)
               mq.push_back('{b: in_data[W-1-i], s: (i == 0), e: (i == W - 1)});
            if (src.size() > 0) void'(src.pop_front());
            pend = 1'b0;
         end
      end
   end

   // Upstream source: once valid is raised it holds word and valid until accepted.
   always @(negedge clk) begin
      if (src.size() == 0) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         pend     = 1'b0;
      end else if (pend || $urandom_range(99) >= gap_pct) begin
         in_valid = 1'b1;
         in_data  = src[0];
         pend     = 1'b1;
      end else begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (dut_vec !== 14'b0000_1_0_00000000) begin
         n_fail++;
         $display("FAIL reset_initial: got %b expected %b", dut_vec, 14'b0000_1_0_00000000);
      end
      rst = 1'b1;
      gap_pct = 0;
      repeat (3) src.push_back(8'($urandom));
      repeat (6) @(negedge clk);
      rst = 1'b0;
      src.delete();
      repeat (2) @(negedge clk);
      n_checks++;
      if (dut_vec !== 14'b0000_1_0_00000000) begin
         n_fail++;
         $display("FAIL reset_midstream: got %b expected %b", dut_vec, 14'b0000_1_0_00000000);
      end
      rst = 1'b1;
   endtask

   task automatic test_single();
      int cyc = 0, nbits = 0, run = 0, z = 0, nsof = 0;
      logic [7:0] got = '0;
      gap_pct = 0;
      src.push_back(8'hF0);
      while ((src.size() > 0 || mq.size() > 0) && cyc < 50) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_cycle%0d: got %b expected %b", cyc, dut_vec, exp_vec());
         end
         if (x_valid) begin
            got = {got[6:0], x};
            nbits++;
            if (sof) nsof++;
            run = x ? run + 1 : 0;
            if (run >= 4) z++;
         end else begin
            run = 0;
         end
      end
      n_checks++;
      if (got !== 8'hF0 || nbits != 8 || nsof != 1 || z != 1 || frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL single_word: got bits=%h n=%0d sof=%0d z=%0d cnt=%0d expected f0 8 1 1 1",
                  got, nbits, nsof, z, frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0, nbits = 0, gaps = 0, nsof = 0;
      bit saw_not_ready = 1'b0;
      logic [15:0] got = '0;
      gap_pct = 0;
      src.push_back(8'hFF);
      src.push_back(8'h0F);
      while ((src.size() > 0 || mq.size() > 0) && cyc < 60) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: got %b expected %b", cyc, dut_vec, exp_vec());
         end
         if (!in_ready) saw_not_ready = 1'b1;
         if (x_valid) begin
            got = {got[14:0], x};
            nbits++;
            if (sof && (nbits == 1 || nbits == 9)) nsof++;
         end else if (nbits > 0 && nbits < 16) begin
            gaps++;
         end
      end
      n_checks++;
      if (got !== 16'hFF0F || nbits != 16 || gaps != 0 || nsof != 2 || !saw_not_ready ||
          frame_cnt !== 8'd3) begin
         n_fail++;
         $display("FAIL back_to_back: got %h n=%0d gaps=%0d sof=%0d nr=%0d cnt=%0d",
                  got, nbits, gaps, nsof, saw_not_ready, frame_cnt);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] w;
      for (int k = 0; k < 4; k++) begin
         w = (k == 0) ? 8'h01 : 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (l_in_ready !== 1'b1 || l_x_valid !== 1'b0 || l_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_idle%0d: got rdy=%b xv=%b busy=%b expected 1 0 0",
                     k, l_in_ready, l_x_valid, l_busy);
         end
         l_in_valid = 1'b1;
         l_in_data  = w;
         @(negedge clk);
         l_in_valid = 1'b0;
         l_in_data  = ~w;
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({l_x, l_x_valid, l_sof, l_eof} !== {w[i], 1'b1, (i == 0), (i == 7)}) begin
               n_fail++;
               $display("FAIL lsb_w%0d_bit%0d: got %b expected %b", k, i,
                        {l_x, l_x_valid, l_sof, l_eof}, {w[i], 1'b1, (i == 0), (i == 7)});
            end
            @(negedge clk);
         end
         n_checks++;
         if (l_x !== 1'b0 || l_x_valid !== 1'b0 || l_frame_cnt !== 8'(k + 1)) begin
            n_fail++;
            $display("FAIL lsb_end%0d: got x=%b xv=%b cnt=%0d expected 0 0 %0d",
                     k, l_x, l_x_valid, l_frame_cnt, k + 1);
         end
      end
   endtask

   task automatic test_random();
      int cyc = 0;
      gap_pct = 40;
      repeat (30) src.push_back(8'($urandom));
      while ((src.size() > 0 || mq.size() > 0) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %b expected %b", cyc, dut_vec, exp_vec());
         end
      end
      n_checks++;
      if (cyc >= 2000) begin
         n_fail++;
         $display("FAIL random_timeout: got %0d cycles expected drain under 2000", cyc);
      end
      gap_pct = 0;
   endtask

   task automatic test_reset_mid();
      int cyc = 0, nbits = 0;
      logic [7:0] got = '0;
      bit first_sof = 1'b0;
      gap_pct = 0;
      src.push_back(8'hAA);
      src.push_back(8'($urandom));
      while (nbits < 3 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (x_valid) nbits++;
      end
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL resetmid_pending: got busy=%b rdy=%b expected 1 0", busy, in_ready);
      end
      rst = 1'b0;
      src.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      n_checks++;
      if (dut_vec !== 14'b0000_1_0_00000000) begin
         n_fail++;
         $display("FAIL resetmid_idle: got %b expected %b", dut_vec, 14'b0000_1_0_00000000);
      end
      src.push_back(8'h80);
      nbits = 0;
      cyc = 0;
      while ((src.size() > 0 || mq.size() > 0) && cyc < 50) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL resetmid_cycle%0d: got %b expected %b", cyc, dut_vec, exp_vec());
         end
         if (x_valid) begin
            if (nbits == 0) first_sof = sof;
            got = {got[6:0], x};
            nbits++;
         end
      end
      n_checks++;
      if (got !== 8'h80 || nbits != 8 || !first_sof || frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL resetmid_restart: got %h n=%0d sof=%b cnt=%0d expected 80 8 1 1",
                  got, nbits, first_sof, frame_cnt);
      end
   endtask

   task automatic test_wrap();
      int cyc = 0, nvalid = 0, gaps = 0;
      bit seen_wrap = 1'b0;
      logic [7:0] prev_cnt = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      gap_pct = 0;
      for (int i = 0; i < 256; i++) src.push_back(8'($urandom));
      while ((src.size() > 0 || mq.size() > 0) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_cycle%0d: got %b expected %b", cyc, dut_vec, exp_vec());
         end
         if (x_valid) nvalid++;
         else if (nvalid > 0 && nvalid < 2048) gaps++;
         if (prev_cnt == 8'd255 && frame_cnt == 8'd0) seen_wrap = 1'b1;
         prev_cnt = frame_cnt;
      end
      n_checks++;
      if (nvalid != 2048 || gaps != 0 || !seen_wrap || frame_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_summary: got valid=%0d gaps=%0d wrap=%b cnt=%0d expected 2048 0 1 0",
                  nvalid, gaps, seen_wrap, frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_lsb_first();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
